// File: rtl/i2c_target2202.sv
// I2C target: oversampled SCL/SDA, 7-bit address match, byte-wide rx/tx handshake, open-drain SDA.
// Optional general-call acceptance is enabled by defining I2C_TGT_GCALL_EN.
module i2c_target2202 #(
   parameter logic [6:0] ADDR = 7'h42
) (
   input  logic       i_cclk,
   input  logic       i_rstn,
   input  logic       i_scl,
   input  logic       i_sda,
   output logic       o_sda_oe,
   input  logic [7:0] i_txdata,
   output logic       o_tx_req,
   output logic [7:0] o_rxdata,
   output logic       o_rx_valid,
   output logic       o_rw,
   output logic       o_busy,
   output logic       o_gcall
);

`ifdef I2C_TGT_GCALL_EN
   localparam bit GCALL_EN = 1'b1;
`else
   localparam bit GCALL_EN = 1'b0;
`endif

   typedef enum logic [2:0] {
      S_IDLE, S_ADDR, S_AACK, S_WRX, S_WACK, S_RTX, S_RACK, S_IGNR
   } state_t;

   state_t     state;
   logic       scl_q1, scl_q2, scl_q3;
   logic       sda_q1, sda_q2, sda_q3;
   logic [2:0] cnt;
   logic [6:0] shreg;
   logic [7:0] txsh;
   logic       ack_phase;
   logic       tx_last;
   logic       rx_pend;

   // Synchronizers idle high so release from reset does not look like a bus condition
   always_ff @(posedge i_cclk or negedge i_rstn) begin
      if (!i_rstn) begin
         scl_q1 <= 1'b1;
         scl_q2 <= 1'b1;
         scl_q3 <= 1'b1;
         sda_q1 <= 1'b1;
         sda_q2 <= 1'b1;
         sda_q3 <= 1'b1;
      end else begin
         scl_q1 <= i_scl;
         scl_q2 <= scl_q1;
         scl_q3 <= scl_q2;
         sda_q1 <= i_sda;
         sda_q2 <= sda_q1;
         sda_q3 <= sda_q2;
      end
   end

   logic       scl_rise, scl_fall, start_det, stop_det;
   logic [7:0] sh_next;
   logic       addr_hit, gcall_hit;

   assign scl_rise  = scl_q2 & ~scl_q3;
   assign scl_fall  = ~scl_q2 & scl_q3;
   assign start_det = scl_q2 & sda_q3 & ~sda_q2;
   assign stop_det  = scl_q2 & ~sda_q3 & sda_q2;
   assign sh_next   = {shreg, sda_q2};
   assign addr_hit  = (sh_next[7:1] == ADDR);
   assign gcall_hit = GCALL_EN && (sh_next == 8'h00);

   always_ff @(posedge i_cclk or negedge i_rstn) begin
      if (!i_rstn) begin
         state      <= S_IDLE;
         cnt        <= 3'd0;
         shreg      <= 7'h00;
         txsh       <= 8'h00;
         ack_phase  <= 1'b0;
         tx_last    <= 1'b0;
         rx_pend    <= 1'b0;
         o_sda_oe   <= 1'b0;
         o_tx_req   <= 1'b0;
         o_rxdata   <= 8'h00;
         o_rx_valid <= 1'b0;
         o_rw       <= 1'b0;
         o_busy     <= 1'b0;
         o_gcall    <= 1'b0;
      end else begin
         o_tx_req   <= 1'b0;
         o_rx_valid <= rx_pend;
         rx_pend    <= 1'b0;
         if (start_det) begin
            state    <= S_ADDR;
            cnt      <= 3'd7;
            o_sda_oe <= 1'b0;
            o_busy   <= 1'b0;
            o_gcall  <= 1'b0;
         end else if (stop_det) begin
            state    <= S_IDLE;
            o_sda_oe <= 1'b0;
            o_busy   <= 1'b0;
            o_gcall  <= 1'b0;
         end else begin
            case (state)
               S_ADDR: if (scl_rise) begin
                  shreg <= sh_next[6:0];
                  cnt   <= cnt - 3'd1;
                  if (cnt == 3'd0) begin
                     ack_phase <= 1'b0;
                     if (addr_hit) begin
                        o_rw   <= sh_next[0];
                        o_busy <= 1'b1;
                        state  <= S_AACK;
                     end else if (gcall_hit) begin
                        o_rw    <= 1'b0;
                        o_busy  <= 1'b1;
                        o_gcall <= 1'b1;
                        state   <= S_AACK;
                     end else begin
                        state <= S_IGNR;
                     end
                  end
               end
               S_AACK: if (scl_fall) begin
                  if (!ack_phase) begin
                     o_sda_oe  <= 1'b1;
                     ack_phase <= 1'b1;
                     if (o_rw) begin
                        o_tx_req <= 1'b1;
                        txsh     <= i_txdata;
                     end
                  end else if (!o_rw) begin
                     o_sda_oe <= 1'b0;
                     cnt      <= 3'd7;
                     state    <= S_WRX;
                  end else begin
                     // The fall ending the ACK clock already carries the MSB
                     o_sda_oe <= ~txsh[7];
                     txsh     <= {txsh[6:0], 1'b0};
                     cnt      <= 3'd6;
                     tx_last  <= 1'b0;
                     state    <= S_RTX;
                  end
               end
               S_WRX: if (scl_rise) begin
                  shreg <= sh_next[6:0];
                  cnt   <= cnt - 3'd1;
                  if (cnt == 3'd0) begin
                     o_rxdata  <= sh_next;
                     rx_pend   <= 1'b1;
                     ack_phase <= 1'b0;
                     state     <= S_WACK;
                  end
               end
               S_WACK: if (scl_fall) begin
                  if (!ack_phase) begin
                     o_sda_oe  <= 1'b1;
                     ack_phase <= 1'b1;
                  end else begin
                     o_sda_oe <= 1'b0;
                     cnt      <= 3'd7;
                     state    <= S_WRX;
                  end
               end
               S_RTX: if (scl_fall) begin
                  if (tx_last) begin
                     o_sda_oe <= 1'b0;
                     state    <= S_RACK;
                  end else begin
                     o_sda_oe <= ~txsh[7];
                     txsh     <= {txsh[6:0], 1'b0};
                     cnt      <= cnt - 3'd1;
                     tx_last  <= (cnt == 3'd0);
                  end
               end
               S_RACK: if (scl_rise) begin
                  if (!sda_q2) begin
                     o_tx_req <= 1'b1;
                     txsh     <= i_txdata;
                     cnt      <= 3'd7;
                     tx_last  <= 1'b0;
                     state    <= S_RTX;
                  end else begin
                     o_busy <= 1'b0;
                     state  <= S_IGNR;
                  end
               end
               S_IGNR:  o_sda_oe <= 1'b0;
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_i2c_target2202.sv
// Directed bench for i2c_target2202: bus-functional I2C initiator with wired-AND SDA.
module tb_i2c_target2202;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic       m_scl = 1'b1;
   logic       m_sda = 1'b1;
   logic       sda_line;
   logic       sda_oe;
   logic [7:0] txdata = 8'h00;
   logic       tx_req;
   logic [7:0] rxdata;
   logic       rx_valid;
   logic       rw;
   logic       busy;
   logic       gcall;

   int errors = 0;
   int checks = 0;

   assign sda_line = m_sda & ~sda_oe;

   always #5 clk = ~clk;

   i2c_target2202 dut (
      .i_cclk    (clk),
      .i_rstn    (rstn),
      .i_scl     (m_scl),
      .i_sda     (sda_line),
      .o_sda_oe  (sda_oe),
      .i_txdata  (txdata),
      .o_tx_req  (tx_req),
      .o_rxdata  (rxdata),
      .o_rx_valid(rx_valid),
      .o_rw      (rw),
      .o_busy    (busy),
      .o_gcall   (gcall)
   );

   // Monitors sampled on the falling clock edge
   int         rxv_pulses = 0, rxv_cycles = 0, txr_pulses = 0, txr_cycles = 0;
   int         oe_viol = 0, oe_hi = 0, busy_hi = 0, rx_lat = 0;
   logic [7:0] rx_log [$];
   logic       rxv_prev = 1'b0, txr_prev = 1'b0, oe_prev = 1'b0, mon_en = 1'b1;
   time        rise_t = 0;

   always @(negedge clk) begin
      if (rx_valid) begin
         rxv_cycles++;
         if (!rxv_prev) begin
            rxv_pulses++;
            rx_log.push_back(rxdata);
            rx_lat = int'(($time - rise_t) / 10);
         end
      end
      if (tx_req) begin
         txr_cycles++;
         if (!txr_prev) txr_pulses++;
      end
      if (mon_en && m_scl && (sda_oe != oe_prev)) oe_viol++;
      if (sda_oe) oe_hi++;
      if (busy) busy_hi++;
      rxv_prev = rx_valid;
      txr_prev = tx_req;
      oe_prev  = sda_oe;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // One SCL clock; returns the wired-AND SDA seen mid-high
   task automatic clk_bit(input logic b, output logic seen);
      wait_cyc(5);
      m_sda = b;
      wait_cyc(5);
      m_scl  = 1'b1;
      rise_t = $time;
      wait_cyc(5);
      seen = sda_line;
      wait_cyc(5);
      m_scl = 1'b0;
   endtask

   task automatic i2c_start();
      if (!m_scl) begin
         wait_cyc(5);
         m_sda = 1'b1;
         wait_cyc(5);
         m_scl = 1'b1;
         wait_cyc(10);
      end
      m_sda = 1'b0;
      wait_cyc(10);
      m_scl = 1'b0;
   endtask

   task automatic i2c_stop();
      wait_cyc(5);
      m_sda = 1'b0;
      wait_cyc(5);
      m_scl = 1'b1;
      wait_cyc(10);
      m_sda = 1'b1;
      wait_cyc(20);
   endtask

   task automatic wr_byte(input logic [7:0] d, output logic ack);
      logic s;
      for (int i = 7; i >= 0; i--) clk_bit(d[i], s);
      clk_bit(1'b1, ack);
   endtask

   task automatic rd8(output logic [7:0] d);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         clk_bit(1'b1, s);
         d[i] = s;
      end
   endtask

   logic [7:0] d;
   logic       ack;
   int         rx0, tx0;
   logic       gc_en;

   initial begin
`ifdef I2C_TGT_GCALL_EN
      gc_en = 1'b1;
`else
      gc_en = 1'b0;
`endif
      wait_cyc(3);
      chk("rst_oe", {31'd0, sda_oe}, 0);
      chk("rst_txreq", {31'd0, tx_req}, 0);
      chk("rst_rxdata", {24'd0, rxdata}, 32'h00);
      chk("rst_rxvalid", {31'd0, rx_valid}, 0);
      chk("rst_rw", {31'd0, rw}, 0);
      chk("rst_busy", {31'd0, busy}, 0);
      chk("rst_gcall", {31'd0, gcall}, 0);
      rstn = 1'b1;
      wait_cyc(10);

      // Write 0xA5, 0x3C to 0x42
      i2c_start();
      wr_byte(8'h84, ack);
      chk("wr_addr_ack", {31'd0, ack}, 0);
      chk("wr_busy", {31'd0, busy}, 1);
      wr_byte(8'hA5, ack);
      chk("wr_b1_ack", {31'd0, ack}, 0);
      chk("wr_rxv_lat", rx_lat, 4);
      wr_byte(8'h3C, ack);
      chk("wr_b2_ack", {31'd0, ack}, 0);
      chk("wr_rx_cnt", rxv_pulses, 2);
      chk("wr_rx0", {24'd0, rx_log[0]}, 32'hA5);
      chk("wr_rx1", {24'd0, rx_log[1]}, 32'h3C);
      chk("wr_rxdata", {24'd0, rxdata}, 32'h3C);
      chk("wr_rw", {31'd0, rw}, 0);
      chk("wr_busy_pre_stop", {31'd0, busy}, 1);
      i2c_stop();
      chk("wr_busy_stop", {31'd0, busy}, 0);
      chk("wr_rxdata_hold", {24'd0, rxdata}, 32'h3C);

      // Read 0x5A (ACK) then 0xC3 (NACK)
      tx0 = txr_pulses;
      txdata = 8'h5A;
      i2c_start();
      wr_byte(8'h85, ack);
      chk("rd_addr_ack", {31'd0, ack}, 0);
      chk("rd_rw", {31'd0, rw}, 1);
      rd8(d);
      chk("rd_b1", {24'd0, d}, 32'h5A);
      txdata = 8'hC3;
      clk_bit(1'b0, ack);
      rd8(d);
      chk("rd_b2", {24'd0, d}, 32'hC3);
      clk_bit(1'b1, ack);
      wait_cyc(6);
      chk("rd_nack_oe", {31'd0, sda_oe}, 0);
      chk("rd_nack_busy", {31'd0, busy}, 0);
      chk("rd_txreq_cnt", txr_pulses - tx0, 2);
      i2c_stop();
      chk("rd_rw_hold", {31'd0, rw}, 1);

      // Address mismatch
      rx0 = rxv_pulses;
      oe_hi = 0;
      busy_hi = 0;
      i2c_start();
      wr_byte(8'h90, ack);
      chk("mm_addr_nack", {31'd0, ack}, 1);
      wr_byte(8'hFF, ack);
      chk("mm_data_nack", {31'd0, ack}, 1);
      i2c_stop();
      chk("mm_oe_never", oe_hi, 0);
      chk("mm_busy_never", busy_hi, 0);
      chk("mm_no_rx", rxv_pulses - rx0, 0);

      // Write then repeated START into a one-byte read
      rx0 = rxv_pulses;
      tx0 = txr_pulses;
      txdata = 8'h96;
      i2c_start();
      wr_byte(8'h84, ack);
      wr_byte(8'h11, ack);
      chk("sr_wr_ack", {31'd0, ack}, 0);
      chk("sr_rw0", {31'd0, rw}, 0);
      i2c_start();
      wr_byte(8'h85, ack);
      chk("sr_addr_ack", {31'd0, ack}, 0);
      chk("sr_rw1", {31'd0, rw}, 1);
      rd8(d);
      chk("sr_rd", {24'd0, d}, 32'h96);
      clk_bit(1'b1, ack);
      i2c_stop();
      chk("sr_rx_cnt", rxv_pulses - rx0, 1);
      chk("sr_rx_val", {24'd0, rx_log[rx0]}, 32'h11);
      chk("sr_txreq_cnt", txr_pulses - tx0, 1);

      // Reset while the target drives a 0 data bit
      txdata = 8'h00;
      i2c_start();
      wr_byte(8'h85, ack);
      wait_cyc(5);
      m_sda = 1'b1;
      wait_cyc(5);
      m_scl = 1'b1;
      wait_cyc(2);
      chk("rst_mid_oe_before", {31'd0, sda_oe}, 1);
      mon_en = 1'b0;
      rstn = 1'b0;
      #1;
      chk("rst_mid_oe_async", {31'd0, sda_oe}, 0);
      wait_cyc(4);
      rstn = 1'b1;
      wait_cyc(6);
      oe_prev = sda_oe;
      mon_en = 1'b1;
      i2c_start();
      wr_byte(8'h84, ack);
      chk("rst_post_ack", {31'd0, ack}, 0);
      wr_byte(8'h5C, ack);
      chk("rst_post_rx", {24'd0, rxdata}, 32'h5C);
      i2c_stop();

      // General call
      rx0 = rxv_pulses;
      i2c_start();
      wr_byte(8'h00, ack);
      chk("gc_ack", {31'd0, ack}, {31'd0, ~gc_en});
      chk("gc_flag", {31'd0, gcall}, {31'd0, gc_en});
      wr_byte(8'h77, ack);
      chk("gc_rx_cnt", rxv_pulses - rx0, gc_en ? 1 : 0);
      if (gc_en) chk("gc_rxdata", {24'd0, rxdata}, 32'h77);
      i2c_stop();
      chk("gc_clr_stop", {31'd0, gcall}, 0);

      chk("rxv_one_cycle", rxv_cycles, rxv_pulses);
      chk("txreq_one_cycle", txr_cycles, txr_pulses);
      chk("oe_scl_high", oe_viol, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
